decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ILL_CNT_W, default 16, width of the illegal-instruction counter.
REQ-002 SHALL have parameter XLEN, default 32, width of the PC and instruction ports.
REQ-003 SHALL have port clk_i  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; it is synchronous and active-high.
REQ-005 SHALL have port instr_valid_i / instr_ready_o  in/out  1/1  upstream handshake.
REQ-006 SHALL have port instr_i / pc_i  input  XLEN/XLEN  fetched instruction and its PC.
REQ-007 SHALL have port flush_i  input  1  discard all buffered and incoming beats.
REQ-008 SHALL have port dec_valid_o / dec_ready_i  out/in  1/1  downstream handshake.
REQ-009 SHALL have port dec_pc_o / dec_instr_o  output  XLEN/XLEN  PC and instruction of the presented beat.
REQ-010 SHALL have decoded outputs ex_op_a_sel_o[1:0], ex_op_b_sel_o[2:0], alu_op_o[4:0], mem_req_o, mem_we_o, mem_size_o[2:0], gpr_we_a_o, wb_src_sel_o, illegal_instr_o, branch_o, jal_o and jalr_o, with the existing RV32I decoder encodings.
REQ-011 SHALL have port mdu_req_o / mdu_op_o  output  1/3  multiply-divide request and operation (func3).
REQ-012 SHALL have port ill_cnt_o  output  ILL_CNT_W  saturating count of illegal beats delivered.

Function
REQ-013 SHALL decode combinationally at the input and register the result; latency is instr accept -> dec_valid_o exactly 1 cycle.
REQ-014 SHALL contain a main output register and a 1-entry skid register, giving full throughput (1 beat/cycle) while dec_ready_i=1.
REQ-015 A beat transfers on the input when instr_valid_i&instr_ready_o, and on the output when dec_valid_o&dec_ready_i.
REQ-016 instr_ready_o SHALL be registered and equal !skid_full; it SHALL NOT depend combinationally on dec_ready_i.
REQ-017 When output is full, not drained, and an input beat is accepted, the beat SHALL go to skid; when skid is full, the next output transfer SHALL load main from skid.
REQ-018 Beats SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush_i.
REQ-019 Presented outputs SHALL hold stable while dec_valid_o=1 and dec_ready_i=0.
REQ-020 flush_i=1 SHALL empty main and skid at the next edge (dec_valid_o=0, instr_ready_o=1); an input beat in the flush cycle SHALL be dropped; flush SHALL take priority over all transfers.
REQ-021 Illegal beats (bits[1:0]!=11, unknown opcode, func3/func7 undefined) SHALL set illegal_instr_o=1 and force gpr_we_a_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o and mdu_req_o to 0.
REQ-022 ill_cnt_o SHALL increment by 1 on each output transfer with illegal_instr_o=1 and saturate at all-ones; it SHALL NOT wrap.
REQ-023 JALR SHALL select OP_A_CURR_PC/OP_B_INCR with jalr_o=1 only for func3=0.
REQ-024 MISC_MEM and SYSTEM SHALL be legal no-ops (all write/request enables 0).

Reset
REQ-025 On rst_i, at the edge, SHALL clear main and skid valid, set instr_ready_o=0 for the reset cycle and 1 after, zero every decoded output and ill_cnt_o; reset mid-transfer SHALL discard the beat.

Configuration
REQ-026 With DECODE_MEXT_EN defined, OP opcode with func7=0x01 SHALL be legal, mdu_req_o=1, mdu_op_o=func3, gpr_we_a_o=1, wb_src_sel_o=WB_EX_RESULT.
REQ-027 Without DECODE_MEXT_EN, that encoding SHALL be illegal and mdu_req_o/mdu_op_o SHALL be constant 0.

Structure
REQ-028 ALU op codes, operand-select codes, LDST sizes, opcodes and a decoded-fields struct SHALL reside in shared package riscv_pkg.
REQ-029 The combinational decode SHALL be sub-module decode_comb; decode_stage owns the buffering, flush and counter.

Verification
REQ-030 add x3,x1,x2 (0x002081B3), dec_ready_i=1 -> next cycle dec_valid_o=1, alu_op_o=ALU_ADD, gpr_we_a_o=1, op A/B = RS1/RS2.
REQ-031 lw x3,0(x1) (0x0000A183) -> mem_req_o=1, mem_we_o=0, mem_size_o=LDST_W, wb_src_sel_o=WB_LSU_DATA.
REQ-032 3 back-to-back beats, dec_ready_i=0 -> 2 accepted, instr_ready_o=0; after ready rises, PCs exit in order 0x0,0x4,0x8.
REQ-033 0x00000000 delivered -> illegal_instr_o=1, all enables 0, ill_cnt_o 0->1; force ill_cnt_o to all-ones, one more illegal -> stays all-ones.
REQ-034 0x022081B3 (mul) -> with DECODE_MEXT_EN: mdu_req_o=1, mdu_op_o=0; without: illegal_instr_o=1.
REQ-035 Two beats buffered, dec_ready_i=0, then flush_i=1 with instr_valid_i=1 -> next cycle dec_valid_o=0, instr_ready_o=1, no beat delivered.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decoder encodings: opcodes, ALU ops, operand selects, LSU sizes
// and the packed decoded-fields record passed from decode to execute.
package riscv_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0f,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6f,
    OPC_SYSTEM   = 7'h73
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_XOR = 5'd2,  ALU_OR  = 5'd3,
    ALU_AND  = 5'd4,  ALU_SLL  = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7,
    ALU_SLT  = 5'd8,  ALU_SLTU = 5'd9,  ALU_EQ  = 5'd10, ALU_NE  = 5'd11,
    ALU_LT   = 5'd12, ALU_GE   = 5'd13, ALU_LTU = 5'd14, ALU_GEU = 5'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_A_REG_A = 2'd0, OP_A_FWD = 2'd1, OP_A_CURR_PC = 2'd2, OP_A_ZERO = 2'd3
  } op_a_sel_e;

  typedef enum logic [2:0] {
    OP_B_REG_B = 3'd0, OP_B_IMM_I = 3'd1, OP_B_IMM_S = 3'd2, OP_B_IMM_B = 3'd3,
    OP_B_IMM_U = 3'd4, OP_B_IMM_J = 3'd5, OP_B_INCR = 3'd6
  } op_b_sel_e;

  // Sizes mirror the load/store func3 field so the decoder can pass it through.
  typedef enum logic [2:0] {
    LDST_B = 3'd0, LDST_H = 3'd1, LDST_W = 3'd2, LDST_BU = 3'd4, LDST_HU = 3'd5
  } ldst_size_e;

  typedef enum logic {
    WB_EX_RESULT = 1'b0, WB_LSU_DATA = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [1:0] op_a_sel;
    logic [2:0] op_b_sel;
    logic [4:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic       wb_src;
    logic       illegal;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       mdu_req;
    logic [2:0] mdu_op;
  } dec_fields_t;

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I decoder; DECODE_MEXT_EN enables the M-extension (func7=0x01) OP encodings.
module decode_comb
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output dec_fields_t dec
);

  logic illegal;

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   begin dec.op_a_sel = OP_A_ZERO;    dec.op_b_sel = OP_B_IMM_U; dec.gpr_we = 1'b1; end
      OPC_AUIPC: begin dec.op_a_sel = OP_A_CURR_PC; dec.op_b_sel = OP_B_IMM_U; dec.gpr_we = 1'b1; end
      OPC_JAL: begin
        dec.op_a_sel = OP_A_CURR_PC; dec.op_b_sel = OP_B_INCR;
        dec.gpr_we = 1'b1; dec.jal = 1'b1;
      end
      OPC_JALR: begin
        dec.op_a_sel = OP_A_CURR_PC; dec.op_b_sel = OP_B_INCR;
        dec.gpr_we = 1'b1; dec.jalr = 1'b1;
        illegal = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        case (funct3)
          3'd0: dec.alu_op = ALU_EQ;
          3'd1: dec.alu_op = ALU_NE;
          3'd4: dec.alu_op = ALU_LT;
          3'd5: dec.alu_op = ALU_GE;
          3'd6: dec.alu_op = ALU_LTU;
          3'd7: dec.alu_op = ALU_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.op_b_sel = OP_B_IMM_I; dec.mem_req = 1'b1; dec.mem_size = funct3;
        dec.gpr_we = 1'b1; dec.wb_src = WB_LSU_DATA;
        illegal = (funct3 == 3'd3) || (funct3 > 3'd5);
      end
      OPC_STORE: begin
        dec.op_b_sel = OP_B_IMM_S; dec.mem_req = 1'b1; dec.mem_we = 1'b1;
        dec.mem_size = funct3;
        illegal = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        dec.op_b_sel = OP_B_IMM_I; dec.gpr_we = 1'b1;
        dec.alu_op = alu_from_f3(funct3, (funct3 == 3'd5) && funct7[5]);
        if (funct3 == 3'd1) illegal = (funct7 != 7'h00);
        if (funct3 == 3'd5) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        dec.gpr_we = 1'b1;
        if (funct7 == 7'h00) begin
          dec.alu_op = alu_from_f3(funct3, 1'b0);
        end else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          dec.alu_op = alu_from_f3(funct3, 1'b1);
`ifdef DECODE_MEXT_EN
        end else if (funct7 == 7'h01) begin
          dec.mdu_req = 1'b1;
          dec.mdu_op  = funct3;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    // Illegal beats carry no side effects downstream.
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: registered decode with a main register plus one skid entry,
// flush, and a saturating illegal-beat counter. DECODE_MEXT_EN enables MDU decode.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int ILL_CNT_W = 16,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [XLEN-1:0]      instr_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 flush_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [XLEN-1:0]      dec_pc_o,
  output logic [XLEN-1:0]      dec_instr_o,
  output logic [1:0]           ex_op_a_sel_o,
  output logic [2:0]           ex_op_b_sel_o,
  output logic [4:0]           alu_op_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [2:0]           mem_size_o,
  output logic                 gpr_we_a_o,
  output logic                 wb_src_sel_o,
  output logic                 illegal_instr_o,
  output logic                 branch_o,
  output logic                 jal_o,
  output logic                 jalr_o,
  output logic                 mdu_req_o,
  output logic [2:0]           mdu_op_o,
  output logic [ILL_CNT_W-1:0] ill_cnt_o
);

  typedef struct packed {
    dec_fields_t     dec;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } beat_t;

  dec_fields_t in_dec;
  beat_t in_beat, main_reg, main_next, skid_reg, skid_next;
  logic main_valid_reg, main_valid_next, skid_valid_reg, skid_valid_next;
  logic ready_reg, ready_next;
  logic [ILL_CNT_W-1:0] ill_cnt_reg, ill_cnt_next;
  logic in_xfer, out_xfer;

  decode_comb u_decode_comb (
    .opcode (instr_i[6:0]),
    .funct3 (instr_i[14:12]),
    .funct7 (instr_i[31:25]),
    .dec    (in_dec)
  );

  assign in_xfer  = instr_valid_i & ready_reg;
  assign out_xfer = main_valid_reg & dec_ready_i;

  always_comb begin
    in_beat.dec     = in_dec;
    in_beat.pc      = pc_i;
    in_beat.instr   = instr_i;
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    ill_cnt_next    = ill_cnt_reg;
    if (flush_i) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      if (out_xfer && main_reg.dec.illegal && ill_cnt_reg != '1)
        ill_cnt_next = ill_cnt_reg + ILL_CNT_W'(1);
      if (!main_valid_reg || out_xfer) begin
        // Skid holds the older beat, so it always refills main first.
        if (skid_valid_reg) begin
          main_next       = skid_reg;
          main_valid_next = 1'b1;
          skid_valid_next = 1'b0;
        end else begin
          main_next       = in_beat;
          main_valid_next = in_xfer;
        end
      end else if (in_xfer) begin
        skid_next       = in_beat;
        skid_valid_next = 1'b1;
      end
    end
    ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      ill_cnt_reg    <= '0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
      ill_cnt_reg    <= ill_cnt_next;
    end
  end

  assign instr_ready_o   = ready_reg;
  assign dec_valid_o     = main_valid_reg;
  assign dec_pc_o        = main_reg.pc;
  assign dec_instr_o     = main_reg.instr;
  assign ex_op_a_sel_o   = main_reg.dec.op_a_sel;
  assign ex_op_b_sel_o   = main_reg.dec.op_b_sel;
  assign alu_op_o        = main_reg.dec.alu_op;
  assign mem_req_o       = main_reg.dec.mem_req;
  assign mem_we_o        = main_reg.dec.mem_we;
  assign mem_size_o      = main_reg.dec.mem_size;
  assign gpr_we_a_o      = main_reg.dec.gpr_we;
  assign wb_src_sel_o    = main_reg.dec.wb_src;
  assign illegal_instr_o = main_reg.dec.illegal;
  assign branch_o        = main_reg.dec.branch;
  assign jal_o           = main_reg.dec.jal;
  assign jalr_o          = main_reg.dec.jalr;
`ifdef DECODE_MEXT_EN
  assign mdu_req_o       = main_reg.dec.mdu_req;
  assign mdu_op_o        = main_reg.dec.mdu_op;
`else
  assign mdu_req_o       = 1'b0;
  assign mdu_op_o        = 3'd0;
`endif
  assign ill_cnt_o       = ill_cnt_reg;

endmodule
